cmd_uart_responder: RTL
=======================

Name: cmd_uart_responder

Overview:
- Robot-side end of the remote command link.
- Deserializes 8N1 UART frames on RX and assembles two bytes (high first) into a 16-bit command with a cmd_rdy/clr_cmd_rdy handshake.
- Serializes the 8-bit response byte (e.g. 0xA5 ack, 0x5A move-done) back on TX.
- Sits between the pins and the command processor, as the counterpart of the remote command initiator.

Parameters:
- BAUD_DIV, 2604: clocks per bit period (50 MHz / 19200 baud); must be ≥ 4.
- TIMEOUT_BITS, 40: inter-byte timeout, in bit periods.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- RX  input  1  serial in, asynchronous to clk, idles high.
- TX  output  1  serial out, idles high.
- cmd  output  16  last assembled command, {high byte, low byte}.
- cmd_rdy  output  1  level; a complete command is held in cmd.
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
- resp  input  8  response byte to transmit.
- trmt  input  1  one-cycle pulse; starts transmission of resp.
- tx_done  output  1  one-cycle pulse after the TX stop bit completes.
- frm_err  output  1  one-cycle pulse on an RX stop bit sampled low.

Behaviour:
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_done=0, frm_err=0. RX synchronizer flops reset to 1. All FSMs return to IDLE / WAIT_HIGH.
- Reset mid-frame aborts the frame silently. TX returns high the cycle after rst.
- RX synchronization: two-flop synchronizer on RX. All RX logic uses the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: count BAUD_DIV/2 (integer division) clocks. Sample: low -> DATA; high -> IDLE (false start, no pulse).
  - DATA: sample every BAUD_DIV clocks, 8 bits, LSB first.
  - STOP: sample after BAUD_DIV clocks. High -> byte valid. Low -> frm_err pulse, byte discarded, and the assembler returns to WAIT_HIGH.
  - Return to IDLE after STOP.
- Assembler FSM states: WAIT_HIGH, WAIT_LOW.
  - Valid byte in WAIT_HIGH -> store as high byte; go to WAIT_LOW; cmd_rdy cleared the same cycle.
  - Valid byte in WAIT_LOW -> cmd={high,low} and cmd_rdy=1 on the next clk edge (one cycle after the stop-bit sample); go to WAIT_HIGH.
  - cmd holds its value until the next full command completes.
- cmd_rdy clearing and precedence:
  - Cleared by clr_cmd_rdy, or by acceptance of a new high byte.
  - If clr_cmd_rdy coincides with command completion, completion wins: cmd_rdy=1.
  - clr_cmd_rdy while cmd_rdy=0 has no effect.
- TX FSM states: IDLE, XMIT.
  - trmt in IDLE latches resp into a 10-bit shift register {1,resp,0}. TX goes low (start bit) the next cycle.
  - Each bit is held exactly BAUD_DIV clocks, LSB first, then the stop bit.
  - tx_done pulses the cycle after the stop bit's final clock; TX stays 1.
  - trmt during XMIT is ignored; resp is not re-latched.
  - trmt in the same cycle that tx_done fires is accepted.
- RX and TX are fully independent (full duplex).

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined: in WAIT_LOW, a counter runs while the RX FSM is IDLE. It reloads when each byte is accepted and is held during frame reception. After TIMEOUT_BITS*BAUD_DIV clocks without a new start bit, the high byte is discarded and the assembler returns to WAIT_HIGH. cmd and cmd_rdy are unchanged.
- Undefined: WAIT_LOW waits indefinitely; no counter is built.

Decomposition:
- Shared package cmd_link_pkg holds:
  - rx_state_t, tx_state_t, asm_state_t enums.
  - Constants: ACK_BYTE=8'hA5, MOVE_DONE_BYTE=8'h5A, DEFAULT_BAUD_DIV=2604.
- One sub-module, uart_tx_core: the TX FSM, baud counter and shift register, with ports clk, rst, trmt, tx_data, TX, tx_done.
- RX and assembler logic stay in the top module.

Test Plan:
- Run all scenarios at BAUD_DIV=16 with fast timeout.
- Command receipt: drive frames 0x60 then 0x20 -> cmd=16'h6020; cmd_rdy rises one clk after the low-byte stop sample; frm_err never pulses.
- Consumer handshake: clr_cmd_rdy pulse -> cmd_rdy=0, cmd stays 16'h6020. Next command 0x2F,0xFF -> cmd=16'h2FFF. Assert clr_cmd_rdy in the completion cycle -> cmd_rdy=1.
- Response transmit: trmt with resp=8'hA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1, each exactly 16 clks; tx_done pulses once, 160 clks after TX first falls. A second trmt mid-frame is ignored.
- Errors: a 4-clk low glitch -> no byte accepted. A frame with stop bit 0 -> frm_err pulse; the following 0x12,0x34 -> cmd=16'h1234.
- Reset and timeout: rst mid-frame -> all outputs at reset values, TX=1. With RX_TIMEOUT_EN, send only 0x55 then idle for more than TIMEOUT_BITS*16 clks, then 0xAB,0xCD -> cmd=16'hABCD (not 16'h55AB).

Source files
------------

// File: rtl/cmd_link_pkg.sv
//==============================================================================
// Module : cmd_link_pkg
// Brief  : Shared state encodings and link constants for the command UART.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package cmd_link_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_XMIT = 1'b1
  } tx_state_t;

  typedef enum logic [0:0] {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } asm_state_t;

  localparam logic [7:0]  ACK_BYTE         = 8'hA5;
  localparam logic [7:0]  MOVE_DONE_BYTE   = 8'h5A;
  localparam int unsigned DEFAULT_BAUD_DIV = 2604;

endpackage

`default_nettype wire

// File: rtl/cmd_uart_responder_if.sv
//==============================================================================
// Module : cmd_uart_responder_if
// Brief  : Command-processor side of the responder: command handshake and
//          response-byte transmit controls.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface cmd_uart_responder_if;
  import cmd_link_pkg::*;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;
  logic        frm_err;

  modport master (
    output clr_cmd_rdy, resp, trmt,
    input  cmd, cmd_rdy, tx_done, frm_err
  );

  modport slave (
    input  clr_cmd_rdy, resp, trmt,
    output cmd, cmd_rdy, tx_done, frm_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_core.sv
//==============================================================================
// Module : uart_tx_core
// Brief  : 8N1 serializer; TX is bit 0 of a right-shifting frame register.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_tx_core
  import cmd_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int unsigned    CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Shifting in ones leaves the line idling high once the stop bit is out.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (trmt) begin
          shift_d = {1'b1, tx_data, 1'b0};
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[9:1]};
          if (bit_q == 4'd9) begin
            tx_done_d = 1'b1;
            state_d   = TX_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign TX      = shift_q[0];
  assign tx_done = tx_done_q;

endmodule

`default_nettype wire

// File: rtl/cmd_uart_responder.sv
//==============================================================================
// Module : cmd_uart_responder
// Brief  : Robot-side UART command link: RX deserializer + two-byte command
//          assembler, TX response serializer.
//          Optional macro RX_TIMEOUT_EN: inter-byte timeout in WAIT_LOW.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module cmd_uart_responder
  import cmd_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
`ifdef RX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_BITS = 40
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic                 TX,
  cmd_uart_responder_if.slave  bus
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          frm_err_q, frm_err_d;
  logic          byte_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      frm_err_q  <= frm_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    frm_err_d  = 1'b0;
    byte_vld   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-start-bit recheck rejects short glitches without any pulse.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_vld   = rx_sync_q;
          frm_err_d  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  asm_state_t  asm_q, asm_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned   TO_CLKS = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned   TW      = $clog2(TO_CLKS);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CLKS - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_expire;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  // Only idle line time in WAIT_LOW counts; a frame in flight freezes it.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_expire = 1'b0;
    if (byte_vld || asm_q == WAIT_HIGH) begin
      to_cnt_d = '0;
    end else if (rx_state_q == RX_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        to_expire = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q     <= WAIT_HIGH;
      high_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      high_q    <= high_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Completion is evaluated after the clear so it overrides a coincident ack.
  always_comb begin
    asm_d     = asm_q;
    high_d    = high_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q && !bus.clr_cmd_rdy;
    if (frm_err_d) begin
      asm_d = WAIT_HIGH;
    end else if (byte_vld) begin
      if (asm_q == WAIT_HIGH) begin
        high_d    = rx_shift_q;
        cmd_rdy_d = 1'b0;
        asm_d     = WAIT_LOW;
      end else begin
        cmd_d     = {high_q, rx_shift_q};
        cmd_rdy_d = 1'b1;
        asm_d     = WAIT_HIGH;
      end
    end
`ifdef RX_TIMEOUT_EN
    else if (to_expire) begin
      asm_d = WAIT_HIGH;
    end
`endif
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.frm_err = frm_err_q;

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (bus.trmt),
    .tx_data (bus.resp),
    .TX      (TX),
    .tx_done (bus.tx_done)
  );

endmodule

`default_nettype wire
